result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
//   Consumer end of the cpu result interface (result / result_empty / trap).
//   Pops each 64-bit value off the cpu result stack and serialises it as a
//   framed little-endian byte stream on a valid/ready port (host/UART side).
//   Reports a nonzero trap as a final trap frame, then halts until reset.
// PARAMETERS
//   WIDTH      64     result word width in bits; multiple of 8
//   HDR_VALUE  8'hA5  header byte of a value frame
//   HDR_TRAP   8'hEE  header byte of a trap frame
// PORTS
//   clk           in   1      clock, rising edge
//   reset         in   1      asynchronous, active-low (0 = reset)
//   result        in   WIDTH  top of cpu result stack; valid while !result_empty
//   result_empty  in   1      1 = cpu result stack empty
//   trap          in   4      cpu trap code; 0 = running/normal
//   result_pop    out  1      pop strobe to cpu result stack
//   tx_data       out  8      stream byte
//   tx_valid      out  1      tx_data valid
//   tx_ready      in   1      sink accepts byte when tx_valid && tx_ready
//   frames_sent   out  16     count of completed value frames; wraps at 0xFFFF->0
//   halted        out  1      trap frame fully sent
// BEHAVIOUR
//   States: IDLE, SEND, TRAP, HALT. NB = WIDTH/8.
//   Reset (reset=0, async): state=IDLE, tx_valid=0, tx_data=0, frames_sent=0,
//     halted=0, shift register=0, byte counter=0. result_pop=0 whenever reset=0.
//   IDLE: trap!=0 has priority -> go TRAP; tx_data=HDR_TRAP, tx_valid=1 next cycle.
//     Else if !result_empty: result_pop=1 (combinational, this cycle only),
//     result captured into shift register same edge, go SEND with
//     tx_data=HDR_VALUE, tx_valid=1 next cycle. Else stay, result_pop=0.
//   result_pop asserted only in IDLE; never two pops without a finished frame.
//   SEND: frame = header then NB bytes, least-significant byte first.
//     Byte advances only on tx_valid && tx_ready; tx_data/tx_valid stable while
//     tx_ready=0. After last byte accepted: frames_sent+1, tx_valid=0, go IDLE.
//     Earliest next pop: cycle after last handshake (1 idle bubble per frame).
//   Trap arriving during SEND: current frame completes, trap seen in IDLE.
//   TRAP: sends HDR_TRAP then {4'h0,trap} (trap resampled at header handshake);
//     after second handshake go HALT.
//   HALT: halted=1, tx_valid=0, result_pop=0; ignores all inputs until reset.
//   Reset mid-frame: frame abandoned, no partial bytes resumed; popped value lost.
// TESTING
//   result=2, empty=0 then 1, tx_ready=1 -> one pop; bytes A5 02 00 00 00 00 00
//     00 00; frames_sent=1; back to IDLE.
//   Same with tx_ready toggling 1/0 each cycle -> identical byte sequence, tx_data
//     stable while stalled, 9 handshakes total.
//   Two stacked values 0x0123456789ABCDEF, 7 -> two pops >=10 cycles apart;
//     A5 EF CD AB 89 67 45 23 01, then A5 07 00..00; frames_sent=2.
//   trap=3 with empty=1 -> EE 03, halted=1, no pop; later empty=0 -> no pop.
//   trap=5 raised mid-frame -> frame finishes (9 bytes) then EE 05.
//   reset=0 pulse after 4th byte -> all outputs to reset values; frames_sent=0.

Source files
------------

// File: rtl/result_drain_if.sv
// Signal bundle between the cpu result stack, the drain block and the byte sink.
// master is the drain side; slave is the cpu/sink environment side.
interface result_drain_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] result;
    logic             result_empty;
    logic [3:0]       trap;
    logic             result_pop;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [15:0]      frames_sent;
    logic             halted;

    modport master (
        input  result, result_empty, trap, tx_ready,
        output result_pop, tx_data, tx_valid, frames_sent, halted
    );

    modport slave (
        output result, result_empty, trap, tx_ready,
        input  result_pop, tx_data, tx_valid, frames_sent, halted
    );
endinterface

// File: rtl/result_drain.sv
// Pops cpu results and streams each as a header byte plus LSB-first data bytes;
// a nonzero trap code is sent as a two-byte trap frame, after which the block halts.
module result_drain #(
    parameter int         WIDTH     = 64,
    parameter logic [7:0] HDR_VALUE = 8'hA5,
    parameter logic [7:0] HDR_TRAP  = 8'hEE
) (
    input  logic          clk,
    input  logic          reset,
    result_drain_if.master bus
);
    localparam int NB    = WIDTH / 8;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TRAP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [15:0]      frames_q, frames_d;
    logic             halted_q, halted_d;
    logic             pop_c;
    logic             hs;

    assign hs = tx_valid_q && bus.tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            frames_q   <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            frames_q   <= frames_d;
            halted_q   <= halted_d;
        end
    end

    // cnt_q counts data bytes already loaded; header is on the wire while it is 0
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        frames_d   = frames_q;
        halted_d   = halted_q;
        pop_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.trap != 4'h0) begin
                    state_d    = TRAP;
                    cnt_d      = '0;
                    tx_data_d  = HDR_TRAP;
                    tx_valid_d = 1'b1;
                end else if (!bus.result_empty) begin
                    pop_c      = 1'b1;
                    state_d    = SEND;
                    shift_d    = bus.result;
                    cnt_d      = '0;
                    tx_data_d  = HDR_VALUE;
                    tx_valid_d = 1'b1;
                end
            end
            SEND: begin
                if (hs) begin
                    if (cnt_q == LAST_CNT) begin
                        tx_valid_d = 1'b0;
                        frames_d   = frames_q + 16'd1;
                        state_d    = IDLE;
                    end else begin
                        tx_data_d = shift_q[7:0];
                        shift_d   = shift_q >> 8;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
            end
            TRAP: begin
                if (hs) begin
                    if (cnt_q == '0) begin
                        // code is taken at the header handshake, not when the trap was first seen
                        tx_data_d = {4'h0, bus.trap};
                        cnt_d     = cnt_q + 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end
                end
            end
            HALT: begin
                tx_valid_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.result_pop  = pop_c && reset;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.frames_sent = frames_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: stacked values and trap codes queue their
// expected frame bytes, which are compared as the sink accepts them.
module tb_result_drain;
    logic clk;
    logic reset;

    result_drain_if #(.WIDTH(64)) dif ();

    result_drain #(.WIDTH(64), .HDR_VALUE(8'hA5), .HDR_TRAP(8'hEE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] stk[$];
    logic [7:0]  exp_q[$];
    int          hs_count = 0;
    int          pop_count = 0;
    int          stray = 0;
    int          cyc = 0;
    int          last_pop_cyc = -1000;
    bit          ready_toggle = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_val(input logic [63:0] v, input bit expect_out);
        stk.push_back(v);
        if (expect_out) begin
            exp_q.push_back(8'hA5);
            for (int i = 0; i < 8; i++) exp_q.push_back(v[i*8 +: 8]);
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !dif.tx_valid && stk.size() == 0) break;
            tick(1);
        end
        check("drain_in_time", 64'(i < budget), 64'd1);
    endtask

    task automatic wait_halted(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (dif.halted) break;
            tick(1);
        end
        check("halt_in_time", 64'(i < budget), 64'd1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (hs_count >= target) break;
            tick(1);
        end
        check("hs_in_time", 64'(i < budget), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // cpu result stack model
    initial begin
        bit pop_now;
        dif.result       = '0;
        dif.result_empty = 1'b1;
        forever begin
            @(negedge clk);
            pop_now = dif.result_pop;
            @(posedge clk);
            if (pop_now && reset) begin
                check("pop_nonempty", 64'(stk.size() != 0), 64'd1);
                check("pop_gap_ok", 64'((cyc - last_pop_cyc) >= 10), 64'd1);
                last_pop_cyc = cyc;
                pop_count++;
                if (stk.size() != 0) void'(stk.pop_front());
            end
            #2;
            dif.result       = (stk.size() != 0) ? stk[0] : 64'd0;
            dif.result_empty = (stk.size() == 0);
        end
    end

    initial begin
        dif.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dif.tx_ready = ready_toggle ? ~dif.tx_ready : 1'b1;
        end
    end

    // byte sink monitor, sampled on the falling edge
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && prev_stall) begin
                check("stall_valid", 64'(dif.tx_valid), 64'd1);
                check("stall_data", 64'(dif.tx_data), 64'(prev_data));
            end
            prev_stall = reset && dif.tx_valid && !dif.tx_ready;
            prev_data  = dif.tx_data;
            if (reset && dif.tx_valid && dif.tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    stray++;
                    check("stray_byte", 64'(stray), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 64'(dif.tx_data), 64'(e));
                end
            end
        end
    end

    initial begin
        int base;
        int pops;
        reset    = 1'b0;
        dif.trap = 4'h0;
        tick(3);
        check("rst_tx_valid", 64'(dif.tx_valid), 64'd0);
        check("rst_tx_data", 64'(dif.tx_data), 64'd0);
        check("rst_frames", 64'(dif.frames_sent), 64'd0);
        check("rst_halted", 64'(dif.halted), 64'd0);
        check("rst_pop", 64'(dif.result_pop), 64'd0);
        reset = 1'b1;
        tick(2);

        // single value, sink always ready
        push_val(64'd2, 1'b1);
        wait_idle(100);
        check("t1_frames", 64'(dif.frames_sent), 64'd1);
        check("t1_pops", 64'(pop_count), 64'd1);

        // same value with a stalling sink
        ready_toggle = 1'b1;
        base = hs_count;
        push_val(64'd2, 1'b1);
        wait_idle(100);
        check("t2_handshakes", 64'(hs_count - base), 64'd9);
        check("t2_frames", 64'(dif.frames_sent), 64'd2);
        ready_toggle = 1'b0;
        tick(2);

        // two stacked values back to back
        pops = pop_count;
        push_val(64'h0123456789ABCDEF, 1'b1);
        push_val(64'd7, 1'b1);
        wait_idle(200);
        check("t3_frames", 64'(dif.frames_sent), 64'd4);
        check("t3_pops", 64'(pop_count - pops), 64'd2);

        // reset pulse after the fourth byte of a frame
        base = hs_count;
        push_val(64'h1122334455667788, 1'b1);
        wait_hs(base + 4, 100);
        tick(1);
        reset = 1'b0;
        last_pop_cyc = -1000;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 64'(dif.tx_valid), 64'd0);
        check("mid_rst_data", 64'(dif.tx_data), 64'd0);
        check("mid_rst_frames", 64'(dif.frames_sent), 64'd0);
        push_val(64'h55, 1'b1);
        tick(3);
        check("mid_rst_pop", 64'(dif.result_pop), 64'd0);
        check("mid_rst_halted", 64'(dif.halted), 64'd0);
        reset = 1'b1;
        wait_idle(100);
        check("t4_frames", 64'(dif.frames_sent), 64'd1);

        // trap raised in the middle of a value frame
        base = hs_count;
        push_val(64'hDEADBEEF_CAFEF00D, 1'b1);
        wait_hs(base + 3, 100);
        dif.trap = 4'h5;
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'h05);
        wait_halted(100);
        tick(2);
        check("t5_frames", 64'(dif.frames_sent), 64'd2);
        check("t5_bytes", 64'(hs_count - base), 64'd11);
        check("t5_left", 64'(exp_q.size()), 64'd0);
        check("t5_valid", 64'(dif.tx_valid), 64'd0);
        dif.trap = 4'h0;
        tick(1);
        reset = 1'b0;
        last_pop_cyc = -1000;
        tick(2);
        check("t5_rst_halted", 64'(dif.halted), 64'd0);
        check("t5_rst_frames", 64'(dif.frames_sent), 64'd0);
        reset = 1'b1;
        tick(2);

        // trap with an empty stack, then data arriving while halted
        pops = pop_count;
        dif.trap = 4'h3;
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'h03);
        wait_halted(100);
        dif.trap = 4'h0;
        push_val(64'hAB, 1'b0);
        tick(20);
        check("t6_halted", 64'(dif.halted), 64'd1);
        check("t6_no_pop", 64'(pop_count - pops), 64'd0);
        check("t6_valid", 64'(dif.tx_valid), 64'd0);
        check("t6_left", 64'(exp_q.size()), 64'd0);
        check("no_stray", 64'(stray), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
